// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
//   Groups the signals between the fetch stage, its program ROM, the decoder
//   and the run/jump control into one bundle.
//
//   master : the fetch stage. It drives adrs/rd to the ROM, inst/inst_pc/
//            inst_valid to the decoder and exports pc.
//   slave  : the environment. It drives run, jmp/jmp_adrs, the ROM data (dout)
//            and the decoder's inst_ready.
// ---------------------------------------------------------------------------
interface inst_fetch_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          run;
   logic          jmp;
   logic [AW-1:0] jmp_adrs;
   logic [AW-1:0] adrs;
   logic          rd;
   logic [DW-1:0] dout;
   logic [DW-1:0] inst;
   logic [AW-1:0] inst_pc;
   logic          inst_valid;
   logic          inst_ready;
   logic [AW-1:0] pc;

   modport master (
      input  run, jmp, jmp_adrs, dout, inst_ready,
      output adrs, rd, inst, inst_pc, inst_valid, pc
   );

   modport slave (
      output run, jmp, jmp_adrs, dout, inst_ready,
      input  adrs, rd, inst, inst_pc, inst_valid, pc
   );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage that sits directly upstream of the program ROM.
//   It owns the program counter and drives the ROM address and read strobe.
//   It captures the combinational ROM output into a small prefetch FIFO and
//   hands {instruction, address} pairs to the decoder over valid/ready.
//
//   Ports
//     clk             system clock, rising edge
//     rst             asynchronous, active-high reset
//     bus (master)    run, jmp, jmp_adrs, dout, inst_ready  (in)
//                     adrs, rd, inst, inst_pc, inst_valid, pc (out)
//
//   A fetch completes at every edge where rd=1. At that edge {dout, pc} is
//   written to the FIFO and pc advances, wrapping modulo 2^AW. A jmp at an
//   edge reloads pc and empties the FIFO. A pop in the same cycle as a jmp is
//   lost together with the rest of the queue.
// ---------------------------------------------------------------------------
module inst_fetch #(
   parameter int            AW       = 8,
   parameter int            DW       = 8,
   parameter int            DEPTH    = 2,
   parameter logic [AW-1:0] PC_RESET = '0
) (
   input  logic         clk,
   input  logic         rst,
   inst_fetch_if.master bus
);
   localparam int             PW       = $clog2(DEPTH);
   localparam int             CW       = PW + 1;
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      STALL = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [DW-1:0] inst_mem_q [DEPTH];
   logic [AW-1:0] pc_mem_q   [DEPTH];

   logic valid;
   logic full;
   logic pop;
   logic push;

   assign valid = (count_q != '0);
   assign full  = (count_q == FULL_CNT);
   assign pop   = valid & bus.inst_ready;
   // A full FIFO can still accept a new fetch when the head leaves in the
   // same cycle. rst is included so the strobe drops immediately on an
   // asynchronous reset, not only at the next clock edge.
   assign push  = bus.run & ~bus.jmp & ~rst & (~full | pop);

   assign bus.adrs       = pc_q;
   assign bus.pc         = pc_q;
   assign bus.rd         = push;
   assign bus.inst_valid = valid;
   assign bus.inst       = valid ? inst_mem_q[rd_ptr_q] : '0;
   assign bus.inst_pc    = valid ? pc_mem_q[rd_ptr_q]   : '0;

   // PC / FIFO occupancy next state
   always_comb begin
      pc_d     = pc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (bus.jmp) begin
         pc_d     = bus.jmp_adrs;
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap without explicit
         // compare logic.
         count_d  = count_q + CW'(push) - CW'(pop);
         rd_ptr_d = rd_ptr_q + PW'(pop);
         wr_ptr_d = wr_ptr_q + PW'(push);
         if (push) begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   // Control state. rd is derived straight from occupancy rather than from
   // the state. That keeps it correct in the first cycle after run rises,
   // when the FIFO may still hold entries from before the stop.
   always_comb begin
      state_d = state_q;
      if (bus.jmp) begin
         state_d = bus.run ? FETCH : IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (bus.run) state_d = FETCH;
            FETCH: begin
               if (!bus.run)         state_d = IDLE;
               else if (full & ~pop) state_d = STALL;
            end
            STALL: begin
               if (!bus.run) state_d = IDLE;
               else if (pop) state_d = FETCH;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= PC_RESET;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // FIFO storage is data only. Stale contents are masked by inst_valid, so
   // it carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[wr_ptr_q] <= bus.dout;
         pc_mem_q[wr_ptr_q]   <= pc_q;
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   inst_fetch_if #(.AW(AW), .DW(DW)) bus ();

   inst_fetch #(
      .AW(AW), .DW(DW), .DEPTH(DEPTH), .PC_RESET(8'h00)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // ROM model: combinational read of the current address
   logic [DW-1:0] rom [256];
   assign bus.dout = rom[bus.adrs];

   // Reference model: FIFO contents as a queue of {inst, address}, plus the PC
   logic [15:0] mq[$];
   logic [7:0]  mpc = 8'h00;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model update: each edge applies jump, pop and fetch from the rules.
   initial begin
      bit m_pop;
      bit m_fetch;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            mpc = 8'h00;
         end else begin
            m_pop   = (mq.size() > 0) && bus.inst_ready;
            m_fetch = bus.run && !bus.jmp && ((mq.size() < DEPTH) || m_pop);
            if (bus.jmp) begin
               mq.delete();
               mpc = bus.jmp_adrs;
            end else begin
               if (m_pop) void'(mq.pop_front());
               if (m_fetch) begin
                  mq.push_back({rom[mpc], mpc});
                  mpc = mpc + 8'h01;
               end
            end
         end
      end
   end

   // Monitor: compares the DUT's presented output against the expected queue.
   initial begin
      bit exp_valid;
      bit exp_rd;
      forever begin
         @(negedge clk or posedge rst);
         #1;
         exp_valid = (mq.size() > 0);
         chk("pc", bus.pc, mpc);
         chk("adrs", bus.adrs, mpc);
         chk("inst_valid", bus.inst_valid, exp_valid);
         if (bus.inst_valid) begin
            if (exp_valid) begin
               chk("inst", bus.inst, mq[0][15:8]);
               chk("inst_pc", bus.inst_pc, mq[0][7:0]);
            end
         end else begin
            chk("inst_idle", bus.inst, 0);
            chk("inst_pc_idle", bus.inst_pc, 0);
         end
         exp_rd = bus.run && !bus.jmp && !rst &&
                  ((mq.size() < DEPTH) || (exp_valid && bus.inst_ready));
         chk("rd", bus.rd, exp_rd);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      rom[0] = 8'h02; rom[1] = 8'h24; rom[2] = 8'h04;
      rom[3] = 8'h25; rom[4] = 8'h26; rom[5] = 8'h27;

      bus.run = 1'b0; bus.jmp = 1'b0; bus.jmp_adrs = '0; bus.inst_ready = 1'b0;
      step(); step();
      rst = 1'b0;

      // streaming fetch with a ready decoder
      bus.run = 1'b1; bus.inst_ready = 1'b1;
      repeat (6) step();

      // asynchronous reset between edges, then restart from 00
      @(posedge clk); #3; rst = 1'b1; #4;
      @(posedge clk); #1; rst = 1'b0;
      repeat (4) step();

      // decoder stalled from reset: FIFO fills, then drains in order
      rst = 1'b1; bus.inst_ready = 1'b0; step();
      rst = 1'b0;
      repeat (4) step();
      bus.inst_ready = 1'b1;
      repeat (4) step();

      // jump while full
      bus.inst_ready = 1'b0;
      repeat (3) step();
      bus.jmp = 1'b1; bus.jmp_adrs = 8'h05; step();
      bus.jmp = 1'b0;
      repeat (3) step();

      // jump to the top of the address space, PC wraps
      bus.inst_ready = 1'b1;
      bus.jmp = 1'b1; bus.jmp_adrs = 8'hFF; step();
      bus.jmp = 1'b0;
      repeat (3) step();

      // stop with two queued entries, drain, resume
      bus.inst_ready = 1'b0;
      repeat (3) step();
      bus.run = 1'b0; bus.inst_ready = 1'b1;
      repeat (4) step();
      bus.run = 1'b1;
      repeat (3) step();

      // randomized traffic
      repeat (3000) begin
         bus.run        = ($urandom_range(0, 9) != 0);
         bus.inst_ready = 1'($urandom_range(0, 1));
         bus.jmp        = ($urandom_range(0, 15) == 0);
         bus.jmp_adrs   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #1; rst = 1'b1; #2; rst = 1'b0;
         end
         step();
      end

      bus.run = 1'b0; bus.jmp = 1'b0;
      step(); step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
